// File: rtl/mem_lsu.sv
// Memory-access stage: non-memory ops pass through combinationally; loads/stores run a req/ack bus transaction.
// Latency: 0 cycles for non-memory ops, n+1 stall cycles plus one DONE cycle when the bus acks n cycles after the request.
// Backpressure: stallreq holds the pipeline while bus_req is up; the controller keeps the inputs stable until DONE ends.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    output logic [4:0]  mem_wd_o,
    output logic        mem_wreg_o,
    output logic [31:0] mem_wdata_o,
    output logic        stallreq,
    output logic        align_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [7:0] EXE_LB_OP   = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP  = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP   = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP  = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP   = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP   = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;
    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] result_q, result_d;

    logic        is_load;
    logic        is_store;
    logic        is_signed;
    logic [1:0]  acc_size;
    logic        mem_op;
    logic        misalign;
    logic [3:0]  lane_sel;
    logic [31:0] store_dat;
    logic [31:0] load_dat;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        acc_size  = SZ_WORD;
        case (mem_aluop_i)
            EXE_LB_OP:  begin is_load  = 1'b1; is_signed = 1'b1; acc_size = SZ_BYTE; end
            EXE_LBU_OP: begin is_load  = 1'b1; acc_size = SZ_BYTE; end
            EXE_LH_OP:  begin is_load  = 1'b1; is_signed = 1'b1; acc_size = SZ_HALF; end
            EXE_LHU_OP: begin is_load  = 1'b1; acc_size = SZ_HALF; end
            EXE_LW_OP:  begin is_load  = 1'b1; acc_size = SZ_WORD; end
            EXE_SB_OP:  begin is_store = 1'b1; acc_size = SZ_BYTE; end
            EXE_SH_OP:  begin is_store = 1'b1; acc_size = SZ_HALF; end
            EXE_SW_OP:  begin is_store = 1'b1; acc_size = SZ_WORD; end
            default:    begin end
        endcase
        mem_op   = is_load | is_store;
        misalign = mem_op && (((acc_size == SZ_HALF) && mem_addr_i[0]) ||
                              ((acc_size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00)));
    end

    // Big-endian lanes: address offset 0 lives in bits [31:24].
    always_comb begin
        case (mem_addr_i[1:0])
            2'd0:    byte_v = bus_rdata[31:24];
            2'd1:    byte_v = bus_rdata[23:16];
            2'd2:    byte_v = bus_rdata[15:8];
            default: byte_v = bus_rdata[7:0];
        endcase
        half_v = mem_addr_i[1] ? bus_rdata[15:0] : bus_rdata[31:16];

        case (acc_size)
            SZ_BYTE: begin
                lane_sel  = 4'b1000 >> mem_addr_i[1:0];
                store_dat = {4{mem_reg2_i[7:0]}};
                load_dat  = {{24{is_signed & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                lane_sel  = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                store_dat = {2{mem_reg2_i[15:0]}};
                load_dat  = {{16{is_signed & half_v[15]}}, half_v};
            end
            default: begin
                lane_sel  = 4'b1111;
                store_dat = mem_reg2_i;
                load_dat  = bus_rdata;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        mem_wd_o    = NOP_REG_ADDR;
        mem_wreg_o  = 1'b0;
        mem_wdata_o = 32'h0;
        stallreq    = 1'b0;
        align_err   = 1'b0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = 32'h0;
        bus_sel     = 4'b0000;
        bus_wdata   = 32'h0;

        if (rst) begin
            mem_wd_o    = mem_wd_i;
            mem_wreg_o  = mem_wreg_i & ~is_store;
            mem_wdata_o = is_store ? 32'h0 : mem_wdata_i;

            case (state_q)
                IDLE: begin
                    if (misalign) begin
                        align_err  = 1'b1;
                        mem_wreg_o = 1'b0;
                    end else if (mem_op) begin
                        bus_req     = 1'b1;
                        stallreq    = 1'b1;
                        mem_wdata_o = 32'h0;
                        state_d     = bus_ack ? DONE : BUSY;
                        if (bus_ack) begin
                            result_d = is_load ? load_dat : 32'h0;
                        end
                    end
                end
                BUSY: begin
                    bus_req     = 1'b1;
                    stallreq    = 1'b1;
                    mem_wdata_o = 32'h0;
                    if (bus_ack) begin
                        result_d = is_load ? load_dat : 32'h0;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    mem_wdata_o = is_store ? 32'h0 : result_q;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // Bus fields follow the stable inputs only while a request is outstanding.
            if (bus_req) begin
                bus_we    = is_store;
                bus_addr  = {mem_addr_i[31:2], 2'b00};
                bus_sel   = lane_sel;
                bus_wdata = store_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed literal cases plus randomized traffic checked every cycle
// against a transaction-level model of the memory stage.
module tb_mem_lsu;

    localparam logic [7:0] LB  = 8'b1110_0000;
    localparam logic [7:0] LBU = 8'b1110_0100;
    localparam logic [7:0] LH  = 8'b1110_0001;
    localparam logic [7:0] LHU = 8'b1110_0101;
    localparam logic [7:0] LW  = 8'b1110_0011;
    localparam logic [7:0] SB  = 8'b1110_1000;
    localparam logic [7:0] SH  = 8'b1110_1001;
    localparam logic [7:0] SW  = 8'b1110_1011;
    localparam logic [7:0] OR_OP  = 8'b0010_0101;
    localparam logic [7:0] ADD_OP = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [31:0] mem_wdata_i;
    logic [7:0]  mem_aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_reg2_i;
    logic [4:0]  mem_wd_o;
    logic        mem_wreg_o;
    logic [31:0] mem_wdata_o;
    logic        stallreq;
    logic        align_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
        .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
        .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
        .stallreq(stallreq), .align_err(align_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [7:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        if (op == LW || op == SW) return 4;
        return 0;
    endfunction

    function automatic bit is_st(input logic [7:0] op);
        return (op == SB || op == SH || op == SW);
    endfunction

    function automatic bit misal(input logic [7:0] op, input logic [31:0] a);
        int sz = acc_size(op);
        return (sz != 0) && ((int'(a[1:0]) % sz) != 0);
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        int sz = acc_size(op);
        int sh = (4 - sz - int'(a[1:0])) * 8;
        logic [31:0] v = rd >> sh;
        if (sz == 1) begin
            v = v & 32'hFF;
            if (op == LB && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (op == LH && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] a);
        int sz = acc_size(op);
        int m = ((1 << sz) - 1) << (4 - sz - int'(a[1:0]));
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_bwd(input logic [7:0] op, input logic [31:0] r2);
        int sz = acc_size(op);
        if (sz == 1) return (r2 & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (r2 & 32'hFFFF) * 32'h0001_0001;
        return r2;
    endfunction

    // m_wait: request outstanding past its first cycle; m_have: result being presented
    logic        m_wait = 1'b0;
    logic        m_have = 1'b0;
    logic [31:0] m_val  = 32'h0;

    always @(posedge clk) begin
        if (!rst) begin
            m_wait <= 1'b0;
            m_have <= 1'b0;
        end else if (m_have) begin
            m_have <= 1'b0;
        end else if (m_wait || (acc_size(mem_aluop_i) != 0 && !misal(mem_aluop_i, mem_addr_i))) begin
            if (bus_ack) begin
                m_have <= 1'b1;
                m_wait <= 1'b0;
                m_val  <= is_st(mem_aluop_i) ? 32'h0 : exp_load(mem_aluop_i, mem_addr_i, bus_rdata);
            end else begin
                m_wait <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int  sz;
        bit  st;
        sz = acc_size(mem_aluop_i);
        st = is_st(mem_aluop_i);
        if (!rst) begin
            chk("rst_wd", {27'h0, mem_wd_o}, 32'h0);
            chk("rst_wreg", {31'h0, mem_wreg_o}, 32'h0);
            chk("rst_wdata", mem_wdata_o, 32'h0);
            chk("rst_ctl", {28'h0, stallreq, align_err, bus_req, bus_we}, 32'h0);
            chk("rst_bus", bus_addr | bus_wdata | {28'h0, bus_sel}, 32'h0);
        end else if (m_have) begin
            chk("done_ctl", {29'h0, stallreq, bus_req, align_err}, 32'h0);
            chk("done_wd", {27'h0, mem_wd_o}, {27'h0, mem_wd_i});
            chk("done_wreg", {31'h0, mem_wreg_o}, {31'h0, mem_wreg_i & ~st});
            chk("done_wdata", mem_wdata_o, m_val);
        end else if (sz != 0 && misal(mem_aluop_i, mem_addr_i)) begin
            chk("mis_ctl", {29'h0, align_err, bus_req, stallreq}, 32'h4);
            chk("mis_wreg", {31'h0, mem_wreg_o}, 32'h0);
        end else if (sz != 0) begin
            chk("req_ctl", {29'h0, stallreq, bus_req, align_err}, 32'h6);
            chk("req_we", {31'h0, bus_we}, {31'h0, st});
            chk("req_addr", bus_addr, mem_addr_i & 32'hFFFF_FFFC);
            chk("req_sel", {28'h0, bus_sel}, {28'h0, exp_sel(mem_aluop_i, mem_addr_i)});
            chk("req_bwd", bus_wdata, exp_bwd(mem_aluop_i, mem_reg2_i));
        end else begin
            chk("pt_ctl", {29'h0, stallreq, bus_req, align_err}, 32'h0);
            chk("pt_wd", {27'h0, mem_wd_o}, {27'h0, mem_wd_i});
            chk("pt_wreg", {31'h0, mem_wreg_o}, {31'h0, mem_wreg_i});
            chk("pt_wdata", mem_wdata_o, mem_wdata_i);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                             input logic [4:0] wd, input logic wreg, input logic [31:0] wdat);
        mem_aluop_i = op;
        mem_addr_i  = a;
        mem_reg2_i  = r2;
        mem_wd_i    = wd;
        mem_wreg_i  = wreg;
        mem_wdata_i = wdat;
    endtask

    // Runs one aligned memory op whose ack arrives 'waits' cycles after the request.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                           input logic [31:0] rd, input int waits, input logic [3:0] e_sel,
                           input logic e_we, input logic [31:0] e_bwd,
                           input logic e_wreg, input logic [31:0] e_res);
        set_instr(op, a, r2, 5'd7, 1'b1, 32'hDEAD_BEEF);
        bus_rdata = rd;
        for (int c = 0; c <= waits; c++) begin
            bus_ack = (c == waits);
            @(negedge clk);
            chk("dir_stall", {31'h0, stallreq}, 32'h1);
            if (c == 0) begin
                chk("dir_sel", {28'h0, bus_sel}, {28'h0, e_sel});
                chk("dir_we", {31'h0, bus_we}, {31'h0, e_we});
                chk("dir_bwd", bus_wdata, e_bwd);
            end
            step();
        end
        bus_ack = 1'b0;
        @(negedge clk);
        chk("dir_done_stall", {31'h0, stallreq}, 32'h0);
        chk("dir_done_wreg", {31'h0, mem_wreg_o}, {31'h0, e_wreg});
        chk("dir_done_wdata", mem_wdata_o, e_res);
        step();
        set_instr(OR_OP, 32'h0, 32'h0, 5'd1, 1'b1, 32'h5555);
        @(negedge clk);
        chk("dir_after_stall", {31'h0, stallreq}, 32'h0);
        step();
    endtask

    initial begin
        logic [7:0]  ops [11] = '{LB, LBU, LH, LHU, LW, SB, SH, SW, OR_OP, ADD_OP, 8'h00};
        logic [31:0] r;
        int          wcnt = 0;

        rst       = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        set_instr(LW, 32'h100, 32'h1, 5'd9, 1'b1, 32'h1);
        @(negedge clk);
        chk("reset_wd", {27'h0, mem_wd_o}, 32'h0);
        chk("reset_req", {31'h0, bus_req}, 32'h0);
        step();
        step();

        rst     = 1'b1;
        bus_ack = 1'b0;
        set_instr(OR_OP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
        @(negedge clk);
        chk("pass_wd", {27'h0, mem_wd_o}, 32'd5);
        chk("pass_wreg", {31'h0, mem_wreg_o}, 32'h1);
        chk("pass_wdata", mem_wdata_o, 32'h1234);
        chk("pass_ctl", {30'h0, stallreq, bus_req}, 32'h0);
        step();

        run_mem(LB,  32'h101, 32'h0,  32'h00F0_0000, 0, 4'b0100, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF0);
        run_mem(LHU, 32'h102, 32'h0,  32'h0000_ABCD, 3, 4'b0011, 1'b0, 32'h0, 1'b1, 32'h0000_ABCD);
        run_mem(SB,  32'h103, 32'hAA, 32'h1234_5678, 1, 4'b0001, 1'b1, 32'hAAAA_AAAA, 1'b0, 32'h0);
        run_mem(LH,  32'h100, 32'h0,  32'h8001_7FFF, 2, 4'b1100, 1'b0, 32'h0, 1'b1, 32'hFFFF_8001);

        set_instr(LW, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0);
        bus_ack = 1'b1;
        @(negedge clk);
        chk("mis_align_err", {31'h0, align_err}, 32'h1);
        chk("mis_bus_stall", {30'h0, bus_req, stallreq}, 32'h0);
        chk("mis_mem_wreg", {31'h0, mem_wreg_o}, 32'h0);
        step();
        bus_ack = 1'b0;

        set_instr(LW, 32'h100, 32'h0, 5'd6, 1'b1, 32'h0);
        @(negedge clk);
        step();
        @(negedge clk);
        chk("busy_req", {31'h0, bus_req}, 32'h1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstbusy_req_stall", {30'h0, bus_req, stallreq}, 32'h0);
        step();
        rst     = 1'b1;
        bus_ack = 1'b1;
        set_instr(OR_OP, 32'h0, 32'h0, 5'd3, 1'b1, 32'h77);
        @(negedge clk);
        chk("late_ack_ctl", {30'h0, bus_req, stallreq}, 32'h0);
        chk("late_ack_wdata", mem_wdata_o, 32'h77);
        step();
        bus_ack = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            wcnt      = m_wait ? wcnt + 1 : 0;
            rst       = ($urandom_range(0, 59) != 0);
            r         = $urandom();
            bus_rdata = r;
            bus_ack   = (wcnt >= 4) || ($urandom_range(0, 2) == 0);
            if (!(m_wait || m_have)) begin
                r = $urandom();
                set_instr(ops[$urandom_range(0, 10)], r, $urandom(),
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom());
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
